// File: rtl/alu_tmr_sequencer_if.sv
// Host-side request/response channel of the temporally redundant ALU sequencer.
// The host drives the master side and the sequencer sits on the slave side.
interface alu_tmr_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_opcode;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-2:0] rsp_hi;
    logic             rsp_cout;
    logic             rsp_corrected;
    logic             rsp_uncorr;

    modport master (
        output req_valid, req_a, req_b, req_opcode, rsp_ready,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cout, rsp_corrected, rsp_uncorr
    );

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, rsp_ready,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cout, rsp_corrected, rsp_uncorr
    );
endinterface

// File: rtl/alu_tmr_sequencer.sv
// Runs each ALU operation twice over separate enable pulses, adds a third run on
// disagreement, majority-votes the result and keeps saturating fault statistics.
module alu_tmr_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_tmr_sequencer_if.slave   host,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_opcode,
    output logic                 alu_en,
    input  logic [WIDTH-1:0]     alu_lo,
    input  logic [WIDTH-2:0]     alu_hi,
    input  logic                 alu_cout,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     stat_corr,
    output logic [CNT_W-1:0]     stat_uncorr
);
    localparam int          RW     = 2 * WIDTH;
    localparam int          SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [2:0]  OP_MUL = 3'b010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC1 = 3'd1,
        GAP1  = 3'd2,
        EXEC2 = 3'd3,
        GAP2  = 3'd4,
        EXEC3 = 3'd5,
        DONE  = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              alu_en_q, alu_en_d;
    logic              req_ready_q, req_ready_d;
    logic [RW-1:0]     r1_q, r1_d, r2_q, r2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]     rsp_q, rsp_d;
    logic              corr_q, corr_d, uncorr_q, uncorr_d;
    logic [CNT_W-1:0]  stat_corr_q, stat_corr_d, stat_uncorr_q, stat_uncorr_d;

    logic [WIDTH-2:0]  hi_masked;
    logic [RW-1:0]     sample;
    logic [RW-1:0]     vote;
    logic              last;
    logic              in_exec;

    // HI floats for every opcode but mul, so it is zeroed before it reaches the compare.
    assign hi_masked = (op_q == OP_MUL) ? alu_hi : '0;
    assign sample    = {alu_cout, hi_masked, alu_lo};
    assign vote      = (r1_q & r2_q) | (r1_q & sample) | (r2_q & sample);
    assign last      = (cnt_q == SW'(SETTLE - 1));
    assign in_exec   = (state_q == EXEC1) || (state_q == EXEC2) || (state_q == EXEC3);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        cnt_d         = '0;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        r1_d          = r1_q;
        r2_d          = r2_q;
        rsp_d         = rsp_q;
        corr_d        = corr_q;
        uncorr_d      = uncorr_q;
        stat_corr_d   = stat_corr_q;
        stat_uncorr_d = stat_uncorr_q;

        if (in_exec && !last) begin
            cnt_d = cnt_q + SW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    a_d     = host.req_a;
                    b_d     = host.req_b;
                    op_d    = host.req_opcode;
                    state_d = EXEC1;
                end
            end
            EXEC1: begin
                if (last) begin
                    r1_d    = sample;
                    state_d = GAP1;
                end
            end
            GAP1:  state_d = EXEC2;
            EXEC2: begin
                if (last) begin
                    r2_d = sample;
                    if (sample == r1_q) begin
                        rsp_d    = r1_q;
                        corr_d   = 1'b0;
                        uncorr_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d  = GAP2;
                    end
                end
            end
            GAP2:  state_d = EXEC3;
            EXEC3: begin
                if (last) begin
                    rsp_d    = vote;
                    corr_d   = (sample == r1_q) || (sample == r2_q);
                    uncorr_d = !((sample == r1_q) || (sample == r2_q));
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (host.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counters bump only on the edge that enters DONE; a clear always wins.
        if (clr_stats) begin
            stat_corr_d   = '0;
            stat_uncorr_d = '0;
        end else if (state_d == DONE && state_q != DONE) begin
            if (corr_d && stat_corr_q != '1) begin
                stat_corr_d = stat_corr_q + CNT_W'(1);
            end
            if (uncorr_d && stat_uncorr_q != '1) begin
                stat_uncorr_d = stat_uncorr_q + CNT_W'(1);
            end
        end

        alu_en_d    = (state_d == EXEC1) || (state_d == EXEC2) || (state_d == EXEC3);
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
    end

    // NOTE: async reset clears every flop, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            alu_en_q      <= 1'b0;
            req_ready_q   <= 1'b0;
            r1_q          <= '0;
            r2_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_q         <= '0;
            corr_q        <= 1'b0;
            uncorr_q      <= 1'b0;
            stat_corr_q   <= '0;
            stat_uncorr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            alu_en_q      <= alu_en_d;
            req_ready_q   <= req_ready_d;
            r1_q          <= r1_d;
            r2_q          <= r2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_q         <= rsp_d;
            corr_q        <= corr_d;
            uncorr_q      <= uncorr_d;
            stat_corr_q   <= stat_corr_d;
            stat_uncorr_q <= stat_uncorr_d;
        end
    end

    assign alu_a              = a_q;
    assign alu_b              = b_q;
    assign alu_opcode         = op_q;
    assign alu_en             = alu_en_q;
    assign host.req_ready     = req_ready_q;
    assign host.rsp_valid     = rsp_valid_q;
    assign host.rsp_lo        = rsp_q[WIDTH-1:0];
    assign host.rsp_hi        = rsp_q[RW-2:WIDTH];
    assign host.rsp_cout      = rsp_q[RW-1];
    assign host.rsp_corrected = corr_q;
    assign host.rsp_uncorr    = uncorr_q;
    assign stat_corr          = stat_corr_q;
    assign stat_uncorr        = stat_uncorr_q;
endmodule

// File: tb/tb_alu_tmr_sequencer.sv
// Randomized and directed bench for alu_tmr_sequencer: a fault-injecting ALU model
// plus a run-level reference model of voting, latency, enable pulses and statistics.
module tb_alu_tmr_sequencer;
    localparam int W  = 16;
    localparam int S  = 1;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_stats = 1'b0;
    logic [W-1:0]  alu_a, alu_b;
    logic [2:0]    alu_opcode;
    logic          alu_en;
    wire  [W-1:0]  alu_lo;
    wire  [W-2:0]  alu_hi;
    wire           alu_cout;
    logic [CW-1:0] stat_corr, stat_uncorr;

    alu_tmr_sequencer_if #(.WIDTH(W)) bus ();

    alu_tmr_sequencer #(.WIDTH(W), .SETTLE(S), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_en     (alu_en),
        .alu_lo     (alu_lo),
        .alu_hi     (alu_hi),
        .alu_cout   (alu_cout),
        .clr_stats  (clr_stats),
        .stat_corr  (stat_corr),
        .stat_uncorr(stat_uncorr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // True ALU function as {cout, hi, lo}; hi is zero for every opcode but mul.
    function automatic logic [2*W-1:0] true_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [2:0] op);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [2*W-1:0] r;
        r = '0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r[W-1:0] = s[W-1:0]; r[2*W-1] = s[W]; end
            3'b001: begin s = {1'b0, a} - {1'b0, b}; r[W-1:0] = s[W-1:0]; r[2*W-1] = s[W]; end
            3'b010: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p; end
            3'b011: r[W-1:0] = ~a;
            3'b100: begin r[W-1:0] = a << 1; r[2*W-1] = a[W-1]; end
            3'b101: begin r[W-1:0] = a >> 1; r[2*W-1] = a[0]; end
            3'b110: r[W-1:0] = a & b;
            default: r[W-1:0] = a | b;
        endcase
        return r;
    endfunction

    // ALU environment: floats outputs when disabled, floats HI unless mul, and
    // corrupts LO with a per-run mask indexed by the enable pulse since accept.
    int           pulse_cnt = 0;
    int           base_cnt  = 0;
    logic [W-1:0] fmask [4];
    logic [W-1:0] cur_mask;
    logic [2*W-1:0] tv;

    always @(posedge alu_en) pulse_cnt <= pulse_cnt + 1;

    always_comb begin
        int r;
        r        = pulse_cnt - base_cnt;
        cur_mask = '0;
        if (r >= 1 && r <= 3) cur_mask = fmask[r];
        tv = true_vec(alu_a, alu_b, alu_opcode);
    end

    assign alu_lo   = alu_en ? (tv[W-1:0] ^ cur_mask) : 'z;
    assign alu_hi   = (alu_en && alu_opcode == 3'b010) ? tv[2*W-2:W] : 'z;
    assign alu_cout = alu_en ? tv[2*W-1] : 1'bz;

    int m_corr   = 0;
    int m_uncorr = 0;

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic [W-1:0] m1, input logic [W-1:0] m2, input logic [W-1:0] m3,
                         input int hold, input bit clr);
        logic [2*W-1:0] r1, r2, r3, exp_res;
        logic [31:0]    exp_en, got_en;
        bit             third, e_corr, e_uncorr;
        int             runs, lat, k, w;

        // Reference: per-run vectors, agreement rules, bitwise vote and timing.
        r1 = true_vec(a, b, op) ^ {{W{1'b0}}, m1};
        r2 = true_vec(a, b, op) ^ {{W{1'b0}}, m2};
        r3 = true_vec(a, b, op) ^ {{W{1'b0}}, m3};
        third = (r1 != r2);
        exp_res = r1;
        if (third) begin
            for (int i = 0; i < 2*W; i++) begin
                exp_res[i] = (int'(r1[i]) + int'(r2[i]) + int'(r3[i])) >= 2;
            end
        end
        e_corr   = third && (r3 == r1 || r3 == r2);
        e_uncorr = third && !e_corr;
        runs     = third ? 3 : 2;
        lat      = third ? 3*S + 2 : 2*S + 1;
        exp_en   = '0;
        for (int i = 0; i <= lat; i++) begin
            exp_en[i] = ((i % (S + 1)) < S) && ((i / (S + 1)) < runs);
        end
        if (clr) begin
            m_corr   = 0;
            m_uncorr = 0;
        end else begin
            if (e_corr   && m_corr   < (1 << CW) - 1) m_corr++;
            if (e_uncorr && m_uncorr < (1 << CW) - 1) m_uncorr++;
        end

        fmask[0] = '0; fmask[1] = m1; fmask[2] = m2; fmask[3] = m3;
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", bus.req_ready, 1);
        base_cnt       = pulse_cnt;
        bus.req_valid  = 1'b1;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_opcode = op;
        clr_stats      = clr;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_op", alu_opcode, op);
        check("req_ready_busy", bus.req_ready, 0);
        got_en    = '0;
        got_en[0] = alu_en;
        k = 0;
        while (!bus.rsp_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (k < 32) got_en[k] = alu_en;
        end
        clr_stats = 1'b0;
        check("latency", k, lat);
        check("en_pattern", got_en, exp_en);
        check("rsp_lo", bus.rsp_lo, exp_res[W-1:0]);
        check("rsp_hi", bus.rsp_hi, exp_res[2*W-2:W]);
        check("rsp_cout", bus.rsp_cout, exp_res[2*W-1]);
        check("rsp_corr", bus.rsp_corrected, e_corr);
        check("rsp_uncorr", bus.rsp_uncorr, e_uncorr);
        check("stat_corr", stat_corr, m_corr);
        check("stat_uncorr", stat_uncorr, m_uncorr);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_a     = ~a;
            @(posedge clk);
            #1;
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_lo", bus.rsp_lo, exp_res[W-1:0]);
            check("hold_req_ready", bus.req_ready, 0);
            check("hold_alu_a", alu_a, a);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("rel_valid", bus.rsp_valid, 0);
        check("rel_req_ready", bus.req_ready, 1);
    endtask

    task automatic reset_mid_exec2();
        int w;
        fmask[0] = '0; fmask[1] = '0; fmask[2] = '0; fmask[3] = '0;
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        base_cnt       = pulse_cnt;
        bus.req_valid  = 1'b1;
        bus.req_a      = 16'h1234;
        bus.req_b      = 16'h0101;
        bus.req_opcode = 3'b000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < S + 1; i++) begin
            @(posedge clk);
            #1;
        end
        check("exec2_en", alu_en, 1);
        rst = 1'b1;
        #1;
        check("rst_en", alu_en, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_stat_corr", stat_corr, 0);
        m_corr   = 0;
        m_uncorr = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", bus.rsp_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb, m1, m2, m3;
        logic [2:0]   rop;
        int           sc;

        bus.req_valid  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_opcode = '0;
        bus.rsp_ready  = 1'b0;
        fmask[0] = '0; fmask[1] = '0; fmask[2] = '0; fmask[3] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_en", alu_en, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_op", alu_opcode, 0);
        check("reset_valid", bus.rsp_valid, 0);
        check("reset_lo", bus.rsp_lo, 0);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_stat", {stat_corr, stat_uncorr}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        do_op(16'h0005, 16'h0003, 3'b000, '0, '0, '0, 0, 1'b0);
        do_op(16'h0100, 16'h0100, 3'b010, '0, '0, '0, 0, 1'b0);
        do_op(16'h0100, 16'h0100, 3'b110, '0, '0, '0, 0, 1'b0);
        do_op(16'h0001, 16'h0001, 3'b000, 16'h0001, '0, '0, 0, 1'b0);
        do_op(16'h0000, 16'h0000, 3'b000, 16'h0001, 16'h0002, 16'h0004, 0, 1'b0);
        do_op(16'hBEEF, 16'h1111, 3'b001, '0, '0, '0, 5, 1'b0);
        reset_mid_exec2();

        // Saturation of the correction counter.
        for (int i = 0; i < 260; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 3'($urandom_range(0, 7));
            m1  = W'(1) << $urandom_range(0, W - 1);
            do_op(ra, rb, rop, m1, '0, '0, 0, 1'b0);
        end
        check("stat_corr_sat", stat_corr, 255);

        // Clear coinciding with an increment.
        do_op(16'h0001, 16'h0001, 3'b000, 16'h0001, '0, '0, 0, 1'b1);
        check("clr_priority", stat_corr, 0);

        // Randomized mix of fault scenarios and back-pressure.
        for (int i = 0; i < 80; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 3'($urandom_range(0, 7));
            m1 = '0; m2 = '0; m3 = '0;
            sc = $urandom_range(0, 3);
            if (sc == 1) m1 = W'($urandom_range(1, 65535));
            if (sc == 2) m2 = W'($urandom_range(1, 65535));
            if (sc == 3) begin
                m1 = W'($urandom);
                m2 = W'($urandom);
                m3 = W'($urandom);
            end
            do_op(ra, rb, rop, m1, m2, m3, $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_tmr_sequencer.md
Name: alu_tmr_sequencer

Overview:
- Sequencer that wraps the combinational 16-bit ALU (add/sub/mul/not/shl/shr/and/or; enable-gated, high-Z outputs when disabled) with temporal redundancy.
- Accepts one operation at a time over a valid/ready request channel and drives the ALU enable and operands.
- Executes the operation twice and compares the results. On mismatch it runs a third time, majority-votes the result and flags the correction.
- Sits between the host/register interface and the ALU instance in the fault-tolerant datapath. Keeps saturating fault statistics.

Parameters:
- WIDTH, 16, operand width and ALU low-result width.
- SETTLE, 1, cycles ALU_EN is held high per run before the result is sampled (>=1).
- CNT_W, 8, width of the saturating fault counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_A  in  WIDTH  operand A.
- REQ_B  in  WIDTH  operand B.
- REQ_OPCODE  in  3  ALU function select (010 = mul).
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer takes result.
- RSP_LO  out  WIDTH  voted result, low word.
- RSP_HI  out  WIDTH-1  voted result, high part (mul only; else 0).
- RSP_COUT  out  1  voted carry.
- RSP_CORRECTED  out  1  third run was needed and two runs agreed.
- RSP_UNCORR  out  1  three runs with no pairwise agreement.
- ALU_A  out  WIDTH  operand to ALU.
- ALU_B  out  WIDTH  operand to ALU.
- ALU_OPCODE  out  3  opcode to ALU.
- ALU_EN  out  1  ALU enable (DataReady).
- ALU_LO  in  WIDTH  ALU low result.
- ALU_HI  in  WIDTH-1  ALU high product.
- ALU_COUT  in  1  ALU carry.
- CLR_STATS  in  1  synchronous clear of both counters.
- STAT_CORR  out  CNT_W  saturating count of corrected operations.
- STAT_UNCORR  out  CNT_W  saturating count of uncorrectable operations.

Behaviour:
- Interface: one clock CLK; RST asynchronous, active-high. On reset, state = IDLE and every output is 0, including ALU_A/B/OPCODE, ALU_EN, RSP_* and STAT_*.
- States: IDLE, EXEC1, GAP1, EXEC2, GAP2, EXEC3, DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY, latch A/B/OPCODE and go to EXEC1.
  - REQ_READY is 0 in every other state.
- EXECn:
  - ALU_EN=1 for SETTLE cycles.
  - On the last cycle, sample result vector R_n = {COUT, HI_masked, LO}.
  - HI_masked = ALU_HI when opcode==010, else 0. This is required: the ALU floats HI for non-mul opcodes and Z/X must never enter the compare.
- GAPn: ALU_EN=0 for exactly one cycle, so the ALU is re-evaluated across a separate enable pulse. Operand outputs are unchanged.
- ALU_A/B/OPCODE hold the latched values from accept until leaving DONE. They are never changed mid-operation.
- After EXEC2:
  - R1==R2: go to DONE with result R1, CORRECTED=0, UNCORR=0.
  - Otherwise go to GAP2, then EXEC3.
- After EXEC3:
  - Result = bitwise majority(R1,R2,R3).
  - CORRECTED=1 if R3==R1 or R3==R2.
  - Otherwise UNCORR=1, CORRECTED=0, result is still the bitwise majority.
- Latency, measured from the accepting edge: RSP_VALID rises on edge 2*SETTLE+1 (no fault) or 3*SETTLE+2 (third run).
- DONE:
  - RSP_VALID=1 and RSP_* are stable until RSP_READY.
  - On RSP_VALID&RSP_READY, go to IDLE. RSP_VALID drops next cycle and REQ_READY rises next cycle; there is no same-cycle bypass.
- Counters:
  - STAT_CORR increments by 1 on entry to DONE with CORRECTED=1.
  - STAT_UNCORR increments by 1 on entry to DONE with UNCORR=1.
  - Both saturate at 2^CNT_W-1.
  - CLR_STATS zeroes both and takes priority over a simultaneous increment.
- RST mid-operation aborts immediately: ALU_EN=0, no response is produced, counters are zeroed.
- RSP_* registers keep their last value while not valid. Consumers qualify with RSP_VALID.

Test Plan:
- Add, no fault, SETTLE=1: A=0x0005, B=0x0003, op=000 -> RSP_VALID on edge 3 after accept; LO=0x0008, HI=0, COUT=0, flags 0; ALU_EN pattern 1,0,1.
- Mul, no fault: A=0x0100, B=0x0100, op=010 -> LO=0x0000, HI=0x0001; with op=110 and ALU model driving HI=Z -> HI=0 and no mismatch.
- Bench flips bit 0 of ALU_LO on run 1 only: A=0x0001, B=0x0001, op=000 -> third run taken, RSP_VALID on edge 5, LO=0x0002, CORRECTED=1, STAT_CORR=1.
- Runs 1, 2 and 3 return distinct corruptions 0x0001/0x0002/0x0004 of true value 0x0000 -> LO=0x0000 (majority), UNCORR=1, STAT_UNCORR=1.
- Back-pressure: hold RSP_READY=0 for 5 cycles -> RSP_* stable, REQ_READY=0, a second REQ_VALID is not accepted; release -> REQ_READY=1 one cycle later.
- RST asserted during EXEC2 -> all outputs 0 asynchronously, no RSP_VALID; 256 forced corrections with CNT_W=8 -> STAT_CORR=255; CLR_STATS concurrent with an increment -> 0.
